u74hc4017_decade_counter: RTL and testbench
===========================================

Name: u74hc4017_decade_counter

Overview:
- Cycle-based model of a 74HC4017 Johnson decade counter with ten decoded one-hot outputs, for the msSimulation component library.
- Inverse role to the library's many-input reducing gates: it takes one count stream and expands it into a ten-way one-hot select plus carry.
- Chip inputs are ordinary signals sampled on the global simulation clock.
- Power loss behaves as a held reset.

Parameters:
- DELAY, 2, propagation delay in clk cycles from internal state update to output change (legal range 1..16).
- IC, 0, initial count loaded on reset (legal 0..9; out-of-range values load 0).

Ports:
- clk  input  1  global simulation clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- vcc  input  1  supply pin; vcc=0 is treated as reset held
- gnd  input  1  ground pin; ignored
- cp0  input  1  count clock; counts on low-to-high
- cp1_n  input  1  count enable / alternate clock; counts on high-to-low
- mr  input  1  master reset, active high, sampled on clk
- q  output  10  decoded count, one-hot; q[k]=1 iff count==k
- co  output  1  carry out; 1 for counts 0-4, 0 for counts 5-9

Behaviour:
- Reset rule:
  - Internal reset vrst = !rst_n || !vcc, evaluated synchronously.
  - While vrst: Johnson state js[4:0] <= enc(IC).
  - Edge-detect registers load the current cp0 and cp1_n, so no phantom edge occurs on release.
  - Every delay-pipeline stage loads dec(enc(IC)).
  - After the first reset edge: q = one-hot IC, co = (IC<5).
- Edge detection uses the previous samples p0 and p1:
  - ev0 = cp0 & !p0 & !cp1_n
  - ev1 = !cp1_n & p1 & cp0
  - count = ev0 | ev1
  - At most one increment per clk, including when both edges land in the same sample.
- State update priority, highest first:
  - vrst
  - mr=1: js <= 5'b00000, overriding a same-cycle count
  - count: js <= {js[3:0], ~js[4]}
  - otherwise hold
- Count sequence 0..9 maps to Johnson codes 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000. Count 9 wraps to 0.
- Invalid Johnson codes are unreachable by construction. If one is detected (e.g. X-free forcing from a bench), the next count event loads 00000 and q reads all-zero until then.
- Decode is combinational from js:
  - q = dec(js)
  - co = !js[4]
- Delay pipeline: decoded {q, co} passes through a DELAY-stage register pipeline.
  - An outputs change appears exactly DELAY clk edges after the edge that updated js.
  - mr and count results both go through the pipeline. Reset loads all stages, so it takes effect at once.
- co rises on the 9->0 wrap and falls on the 4->5 step (each seen after DELAY).
- Reset mid-count: the count is discarded and the outputs jump to IC on the reset edge, with no pipeline drain.
- vcc returning to 1 with rst_n=1 resumes counting from IC. A cp0 level already high at power return does not count.

Decomposition:
- Shared package u74hc_pkg holds:
  - the Johnson code constants
  - function enc(int) -> 5-bit code
  - function dec(5-bit) -> 10-bit one-hot
  - function valid_johnson
  These are reused by a later 4022 octal variant.
- One sub-module, prop_delay_pipe:
  - parameters WIDTH, DEPTH
  - synchronous load-all on vrst
  - the same pipeline is reused by other timed components

Test Plan:
- Reset: IC=0, DELAY=2, rst_n=0 for 2 clk -> q=10'b0000000001, co=1 immediately. With IC=7 -> q=10'b0010000000, co=0.
- Counting: cp1_n=0, 12 cp0 pulses (high 3 clk, low 3 clk) -> q ends one-hot 2. co goes 1->0 after pulse 5 and back to 1 after pulse 10. Each transition lands exactly 2 clk after the cp0 rising sample.
- Enable/alternate clock: cp1_n=1, 5 cp0 pulses -> no change from count 0. Then cp0=1 held and cp1_n falls -> count 1. cp0 rise and cp1_n fall in the same sample -> exactly one increment.
- Master reset: count at 7, mr=1 on the same clk as a cp0 rise -> count 0, q=10'b0000000001 after DELAY. Pulses while mr=1 are ignored.
- Power loss: IC=3, count at 6, vcc=0 for 4 clk with cp0 toggling -> q=10'b0000001000 from the first vcc=0 edge and held. vcc=1 with cp0 already high -> no count until the next rise.
- Delay sweep: DELAY=1 and DELAY=5, single cp0 edge at clk t -> q changes at exactly t+DELAY and no earlier.

Source files
------------

// File: rtl/u74hc_pkg.sv
// Johnson-code helpers shared by the 74HC40xx counter family: code table,
// count-to-code encoder, one-hot decoder and a validity check.
package u74hc_pkg;

  localparam int unsigned NUM_COUNTS = 10;

  localparam logic [4:0] JS_C0 = 5'b00000;
  localparam logic [4:0] JS_C1 = 5'b00001;
  localparam logic [4:0] JS_C2 = 5'b00011;
  localparam logic [4:0] JS_C3 = 5'b00111;
  localparam logic [4:0] JS_C4 = 5'b01111;
  localparam logic [4:0] JS_C5 = 5'b11111;
  localparam logic [4:0] JS_C6 = 5'b11110;
  localparam logic [4:0] JS_C7 = 5'b11100;
  localparam logic [4:0] JS_C8 = 5'b11000;
  localparam logic [4:0] JS_C9 = 5'b10000;

  // Out-of-range counts fall back to the zero code.
  function automatic logic [4:0] enc(input int n);
    case (n)
      1:       return JS_C1;
      2:       return JS_C2;
      3:       return JS_C3;
      4:       return JS_C4;
      5:       return JS_C5;
      6:       return JS_C6;
      7:       return JS_C7;
      8:       return JS_C8;
      9:       return JS_C9;
      default: return JS_C0;
    endcase
  endfunction

  // Invalid codes decode to all-zero.
  function automatic logic [9:0] dec(input logic [4:0] js);
    case (js)
      JS_C0:   return 10'b0000000001;
      JS_C1:   return 10'b0000000010;
      JS_C2:   return 10'b0000000100;
      JS_C3:   return 10'b0000001000;
      JS_C4:   return 10'b0000010000;
      JS_C5:   return 10'b0000100000;
      JS_C6:   return 10'b0001000000;
      JS_C7:   return 10'b0010000000;
      JS_C8:   return 10'b0100000000;
      JS_C9:   return 10'b1000000000;
      default: return 10'b0000000000;
    endcase
  endfunction

  function automatic logic valid_johnson(input logic [4:0] js);
    return (dec(js) != 10'b0);
  endfunction

endpackage

// File: rtl/prop_delay_pipe.sv
// Fixed-latency register pipeline modelling propagation delay; a load pulse
// fills every stage at once so the output snaps without draining.
module prop_delay_pipe #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= load_val_i;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/u74hc4017_decade_counter.sv
// Cycle-based 74HC4017 Johnson decade counter: edge-detected count inputs,
// 5-bit Johnson state, one-hot decode and carry behind a DELAY-cycle pipe.
module u74hc4017_decade_counter
  import u74hc_pkg::*;
#(
  parameter int DELAY = 2,
  parameter int IC    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vcc,
  input  logic       gnd,
  input  logic       cp0,
  input  logic       cp1_n,
  input  logic       mr,
  output logic [9:0] q,
  output logic       co
);

  localparam int         DEPTH  = (DELAY < 1) ? 1 : ((DELAY > 16) ? 16 : DELAY);
  localparam logic [4:0] JS_IC  = enc(IC);
  localparam logic [10:0] OUT_IC = {dec(JS_IC), ~JS_IC[4]};

  logic        vrst;
  logic        p0_q, p1_q;
  logic        ev0, ev1, count;
  logic [4:0]  js_q, js_d;
  logic [10:0] out_d, out_q;
  logic        gnd_unused;

  assign gnd_unused = gnd;
  assign vrst       = !rst_n || !vcc;

  // Both edge forms OR together, so coincident edges still give one step.
  assign ev0   = cp0 & !p0_q & !cp1_n;
  assign ev1   = !cp1_n & p1_q & cp0;
  assign count = ev0 | ev1;

  always_comb begin
    js_d = js_q;
    if (mr) begin
      js_d = JS_C0;
    end else if (count) begin
      js_d = valid_johnson(js_q) ? {js_q[3:0], ~js_q[4]} : JS_C0;
    end
  end

  // Edge samplers track the pins even in reset so release never sees a phantom edge.
  always_ff @(posedge clk) begin
    p0_q <= cp0;
    p1_q <= cp1_n;
    if (vrst) js_q <= JS_IC;
    else      js_q <= js_d;
  end

  assign out_d = {dec(js_q), ~js_q[4]};

  prop_delay_pipe #(
    .WIDTH(11),
    .DEPTH(DEPTH)
  ) u_delay (
    .clk_i      (clk),
    .load_i     (vrst),
    .load_val_i (OUT_IC),
    .d_i        (out_d),
    .q_o        (out_q)
  );

  assign q  = out_q[10:1];
  assign co = out_q[0];

endmodule

// File: tb/tb_u74hc4017_decade_counter.sv
// Directed-vector bench: five counter instances (varied IC/DELAY) share one
// stimulus stream; expectations are hand-computed per phase.
module tb_u74hc4017_decade_counter;

  logic clk = 1'b0;
  logic rst_n, vcc, gnd, cp0, cp1_n, mr;
  logic [9:0] q_a, q_b, q_c, q_d, q_e;
  logic       co_a, co_b, co_c, co_d, co_e;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  u74hc4017_decade_counter #(.DELAY(2), .IC(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .cp0(cp0), .cp1_n(cp1_n),
    .mr(mr), .q(q_a), .co(co_a));
  u74hc4017_decade_counter #(.DELAY(2), .IC(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .cp0(cp0), .cp1_n(cp1_n),
    .mr(mr), .q(q_b), .co(co_b));
  u74hc4017_decade_counter #(.DELAY(2), .IC(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .cp0(cp0), .cp1_n(cp1_n),
    .mr(mr), .q(q_c), .co(co_c));
  u74hc4017_decade_counter #(.DELAY(1), .IC(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .cp0(cp0), .cp1_n(cp1_n),
    .mr(mr), .q(q_d), .co(co_d));
  u74hc4017_decade_counter #(.DELAY(5), .IC(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .vcc(vcc), .gnd(gnd), .cp0(cp0), .cp1_n(cp1_n),
    .mr(mr), .q(q_e), .co(co_e));

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    cp0 = 1'b1; step(3);
    cp0 = 1'b0; step(3);
  endtask

  function automatic logic [9:0] oh(input int k);
    logic [9:0] v;
    v = 10'b0;
    v[k % 10] = 1'b1;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; vcc = 1'b1; gnd = 1'b0; cp0 = 1'b0; cp1_n = 1'b0; mr = 1'b0;

    // Reset: outputs take IC on the very first reset edge
    step(1);
    chk_vec("rst_q_ic0",  q_a,  10'b0000000001);
    chk_vec("rst_co_ic0", co_a, 1'b1);
    chk_vec("rst_q_ic7",  q_b,  10'b0010000000);
    chk_vec("rst_co_ic7", co_b, 1'b0);
    step(1);
    chk_vec("rst_q_ic3",  q_c,  10'b0000001000);
    chk_vec("rst_q_d5",   q_e,  10'b0000000001);
    rst_n = 1'b1;
    step(2);
    chk_vec("idle_q", q_a, 10'b0000000001);

    // First pulse: latency check for DELAY 1, 2 and 5
    cp0 = 1'b1;
    step(1);
    chk_vec("lat_t0_d2", q_a, 10'b0000000001);
    chk_vec("lat_t0_d1", q_d, 10'b0000000001);
    step(1);
    chk_vec("lat_t1_d2", q_a, 10'b0000000001);
    chk_vec("lat_t1_d1", q_d, 10'b0000000010);
    step(1);
    chk_vec("lat_t2_d2", q_a, 10'b0000000010);
    chk_vec("lat_t2_d5", q_e, 10'b0000000001);
    cp0 = 1'b0;
    step(2);
    chk_vec("lat_t4_d5", q_e, 10'b0000000001);
    step(1);
    chk_vec("lat_t5_d5", q_e, 10'b0000000010);

    // Pulses 2..12: carry falls at 5, rises on wrap at 10
    for (int k = 2; k <= 12; k++) begin
      pulse();
      chk_vec($sformatf("cnt_q_%0d", k),  q_a,  oh(k));
      chk_vec($sformatf("cnt_co_%0d", k), co_a, ((k % 10) < 5) ? 1'b1 : 1'b0);
    end
    chk_vec("cnt_q_ic7", q_b, 10'b1000000000);
    chk_vec("cnt_q_ic3", q_c, 10'b0000100000);

    // cp1_n high inhibits cp0 counting
    cp1_n = 1'b1;
    for (int k = 0; k < 5; k++) pulse();
    chk_vec("inhibit_q", q_a, 10'b0000000100);
    cp0 = 1'b1; step(2);
    cp1_n = 1'b0; step(3);
    chk_vec("cp1n_fall_q", q_a, 10'b0000001000);
    cp0 = 1'b0; cp1_n = 1'b1; step(2);
    cp0 = 1'b1; cp1_n = 1'b0; step(3);
    chk_vec("both_edge_q", q_a, 10'b0000010000);
    step(3);
    chk_vec("both_edge_hold", q_a, 10'b0000010000);
    cp0 = 1'b0; step(3);

    // Master reset from count 7 with a coincident cp0 rise
    for (int k = 0; k < 3; k++) pulse();
    chk_vec("pre_mr_q", q_a, 10'b0010000000);
    mr = 1'b1; cp0 = 1'b1;
    step(2);
    chk_vec("mr_t1_q", q_a, 10'b0010000000);
    step(1);
    chk_vec("mr_t2_q", q_a, 10'b0000000001);
    cp0 = 1'b0; step(3);
    pulse(); pulse();
    chk_vec("mr_hold_q", q_a, 10'b0000000001);
    mr = 1'b0; step(3);
    chk_vec("mr_rel_q",  q_a, 10'b0000000001);
    chk_vec("mr_rel_co", co_a, 1'b1);
    chk_vec("mr_rel_c",  q_c, 10'b0000000001);

    // Power loss on IC=3 instance at count 6
    for (int k = 0; k < 6; k++) pulse();
    chk_vec("pwr_pre_q", q_c, 10'b0001000000);
    vcc = 1'b0; cp0 = 1'b1;
    step(1);
    chk_vec("pwr_t0_q", q_c, 10'b0000001000);
    cp0 = 1'b0; step(1);
    cp0 = 1'b1; step(1);
    cp0 = 1'b0; step(1);
    chk_vec("pwr_t3_q", q_c, 10'b0000001000);
    cp0 = 1'b1; step(1);
    vcc = 1'b1; step(4);
    chk_vec("pwr_ret_noedge", q_c, 10'b0000001000);
    chk_vec("pwr_ret_a",      q_a, 10'b0000000001);
    cp0 = 1'b0; step(3);
    pulse();
    chk_vec("pwr_ret_cnt", q_c, 10'b0000010000);
    chk_vec("pwr_ret_d",   q_d, 10'b0000000010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
